// File: rtl/rf_wb_pkg.sv
// Shared constants and skid-buffer state encoding for the register-file
// write-back select block.
package rf_wb_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NSRC_DEF  = 6;
  localparam int SELW_DEF  = 3;
  localparam int ERRCNT_W  = 8;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;
endpackage

// File: rtl/rf_wb_select_if.sv
// Handshake bundle between a write-data producer and rf_wb_select.
// RF_WB_SELECT_ERRCNT_EN adds the saturating error counter output.
interface rf_wb_select_if
  import rf_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int SELW  = SELW_DEF
);
  logic [SELW-1:0]       sel;
  logic [NSRC*WIDTH-1:0] src_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic                  err_clr;
  logic [WIDTH-1:0]      wd_data;
  logic                  wd_valid;
  logic                  wd_ready;
  logic                  sel_err;
`ifdef RF_WB_SELECT_ERRCNT_EN
  logic [ERRCNT_W-1:0]   err_count;

  modport master (
    output sel, src_data, in_valid, flush, err_clr, wd_ready,
    input  in_ready, wd_data, wd_valid, sel_err, err_count
  );
  modport slave (
    input  sel, src_data, in_valid, flush, err_clr, wd_ready,
    output in_ready, wd_data, wd_valid, sel_err, err_count
  );
`else
  modport master (
    output sel, src_data, in_valid, flush, err_clr, wd_ready,
    input  in_ready, wd_data, wd_valid, sel_err
  );
  modport slave (
    input  sel, src_data, in_valid, flush, err_clr, wd_ready,
    output in_ready, wd_data, wd_valid, sel_err
  );
`endif
endinterface

// File: rtl/rf_wb_skid.sv
// Two-entry skid buffer. out_q is the head entry driving the output;
// skid_q catches the word accepted while the head is stalled.
module rf_wb_skid
  import rf_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);
  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             acc, xfer;

  // Outputs come straight from state so they never depend on out_ready.
  assign in_ready  = (state_q != SK_FULL);
  assign out_valid = (state_q != SK_EMPTY);
  assign dout      = out_q;
  assign acc       = in_valid & in_ready;
  assign xfer      = out_ready & out_valid;

  // Next-state and entry movement; flush overrides any same-cycle accept.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SK_EMPTY;
    end else begin
      case (state_q)
        SK_EMPTY: if (acc) begin
          out_d   = din;
          state_d = SK_ONE;
        end
        SK_ONE: begin
          if (acc && xfer)      out_d = din;
          else if (acc) begin
            skid_d  = din;
            state_d = SK_FULL;
          end else if (xfer)    state_d = SK_EMPTY;
        end
        SK_FULL: if (xfer) begin
          out_d   = skid_q;
          state_d = SK_ONE;
        end
        default: state_d = SK_EMPTY;
      endcase
    end
  end

  // State and entry registers, async clear to empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SK_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/rf_wb_select.sv
// Register-file write-back source select: decodes sel into one of NSRC
// sources (zero for out-of-range sel), buffers it through rf_wb_skid and
// tracks a sticky out-of-range error. RF_WB_SELECT_ERRCNT_EN adds an
// 8-bit saturating out-of-range counter.
module rf_wb_select
  import rf_wb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NSRC  = NSRC_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic clk,
  input  logic reset,
  rf_wb_select_if.slave bus
);
  logic [WIDTH-1:0] dec;
  logic             oor;
  logic             oor_acc;
  logic             sel_err_q, sel_err_d;

  // Full decode: every sel value yields a defined word, zero when out of range.
  always_comb begin
    dec = '0;
    for (int k = 0; k < NSRC; k++)
      if (bus.sel == SELW'(k)) dec = bus.src_data[k*WIDTH +: WIDTH];
  end

  assign oor     = (int'(bus.sel) >= NSRC);
  assign oor_acc = bus.in_valid & bus.in_ready & oor;

  rf_wb_skid #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.flush),
    .din       (dec),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .dout      (bus.wd_data),
    .out_valid (bus.wd_valid),
    .out_ready (bus.wd_ready)
  );

  // Sticky error: a new out-of-range accept beats a same-cycle clear.
  always_comb begin
    sel_err_d = (sel_err_q & ~bus.err_clr) | oor_acc;
  end

  // Sticky error register; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;

`ifdef RF_WB_SELECT_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of out-of-range accepts; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus.err_clr)                      err_cnt_d = '0;
    else if (oor_acc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign bus.err_count = err_cnt_q;
`endif
endmodule
